// File: rtl/btn_conditioner_pkg.sv
// Shared defaults and per-channel FSM state encoding for the pushbutton conditioner.
package btn_conditioner_pkg;

   localparam int DEF_NUM_BTN    = 4;
   localparam int DEF_DEB_LEN    = 4;
   localparam int DEF_LONG_TICKS = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } btn_state_t;

endpackage

// File: rtl/btn_debounce_cell.sv
// One pushbutton channel: tick-sampled shift-register debounce, press/long-press FSM.
module btn_debounce_cell
   import btn_conditioner_pkg::*;
#(
   parameter int DEB_LEN    = DEF_DEB_LEN,
   parameter int LONG_TICKS = DEF_LONG_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn_sync,
   output logic level,
   output logic pulse,
   output logic long_pulse
);

   localparam int CNT_W = (LONG_TICKS > 1) ? $clog2(LONG_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_TICKS - 1);

   logic [DEB_LEN-1:0] shift_q;
   logic [DEB_LEN-1:0] shift_nxt;
   btn_state_t         state_q;
   btn_state_t         state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   if (DEB_LEN > 1) begin : g_wide
      assign shift_nxt = {shift_q[DEB_LEN-2:0], btn_sync};
   end else begin : g_one
      assign shift_nxt = btn_sync;
   end

   // Level only moves once the whole sample window agrees; mixed windows hold it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         level   <= 1'b0;
      end else begin
         if (tick) begin
            shift_q <= shift_nxt;
         end
         if (&shift_q) begin
            level <= 1'b1;
         end else if (~|shift_q) begin
            level <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pulse      = 1'b0;
      long_pulse = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (level) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               pulse   = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!level) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == CNT_LAST) begin
                  state_d    = ST_HELD;
                  long_pulse = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_HELD: begin
            // Counter stays parked at its last value until release.
            if (!level) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner top: input synchronizers, shared debounce tick, per-channel cells.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int NUM_BTN    = DEF_NUM_BTN,
   parameter int DEB_LEN    = DEF_DEB_LEN,
   parameter int LONG_TICKS = DEF_LONG_TICKS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_debounce,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic [NUM_BTN-1:0] btn_long
);

   logic [NUM_BTN-1:0] btn_s1;
   logic [NUM_BTN-1:0] btn_s2;
   logic               deb_s1;
   logic               deb_s2;
   logic               deb_s3;
   logic               tick;

   // clk_debounce is sampled as data; deb_s3 is the edge-detector history bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         deb_s1 <= 1'b0;
         deb_s2 <= 1'b0;
         deb_s3 <= 1'b0;
      end else begin
         btn_s1 <= btn_in;
         btn_s2 <= btn_s1;
         deb_s1 <= clk_debounce;
         deb_s2 <= deb_s1;
         deb_s3 <= deb_s2;
      end
   end

   assign tick = deb_s2 & ~deb_s3;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
      btn_debounce_cell #(
         .DEB_LEN    (DEB_LEN),
         .LONG_TICKS (LONG_TICKS)
      ) u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .tick       (tick),
         .btn_sync   (btn_s2[i]),
         .level      (btn_level[i]),
         .pulse      (btn_pulse[i]),
         .long_pulse (btn_long[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a per-cycle behavioural reference model.
module tb_btn_conditioner;

   localparam int NB = 4;
   localparam int DL = 4;
   localparam int LT = 64;

   logic          clk;
   logic          rst_n;
   logic          clk_debounce;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_pulse;
   logic [NB-1:0] btn_long;

   int checks = 0;
   int errors = 0;

   btn_conditioner #(
      .NUM_BTN    (NB),
      .DEB_LEN    (DL),
      .LONG_TICKS (LT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_debounce (clk_debounce),
      .btn_in       (btn_in),
      .btn_level    (btn_level),
      .btn_pulse    (btn_pulse),
      .btn_long     (btn_long)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   // Reference model: sampled-history view of sync/tick, run-length debounce, tick counting
   int            run     [NB];
   bit            last_v  [NB];
   bit            m_level [NB];
   bit            lvl_prev[NB];
   int            tcount  [NB];
   bit            armed   [NB];
   bit            d1, d2, d3;
   logic [NB-1:0] i1, i2;
   logic [NB-1:0] e_level, e_pulse, e_long;

   int            deb_rises = 0;
   int            pulse_cnt [NB];
   int            long_cnt  [NB];
   int            rise_at   [NB];
   int            long_at   [NB];
   logic [NB-1:0] mon_prev;
   bit            cap_en   = 1'b0;
   bit            cap_done = 1'b0;
   logic [NB-1:0] cap_word = '0;

   initial begin
      bit ev, tick_now, cur_d;
      logic [NB-1:0] cur_i;
      for (int c = 0; c < NB; c++) begin
         pulse_cnt[c] = 0; long_cnt[c] = 0; rise_at[c] = -1000; long_at[c] = -1000;
      end
      mon_prev = '0;
      forever begin
         @(posedge clk);
         cur_d = clk_debounce;
         cur_i = btn_in;
         if (!rst_n) begin
            d1 = 0; d2 = 0; d3 = 0; i1 = '0; i2 = '0;
            for (int c = 0; c < NB; c++) begin
               run[c] = DL; last_v[c] = 0; m_level[c] = 0; lvl_prev[c] = 0;
               tcount[c] = 0; armed[c] = 0;
            end
            e_level = '0; e_pulse = '0; e_long = '0;
         end else begin
            ev       = d2 & ~d3;
            tick_now = d1 & ~d2;
            for (int c = 0; c < NB; c++) begin
               if (run[c] >= DL) m_level[c] = last_v[c];
               if (ev) begin
                  if (i2[c] == last_v[c]) begin
                     if (run[c] < DL) run[c]++;
                  end else begin
                     last_v[c] = i2[c];
                     run[c]    = 1;
                  end
               end
               e_pulse[c] = m_level[c] & ~lvl_prev[c];
               e_long[c]  = 1'b0;
               if (e_pulse[c]) begin
                  tcount[c] = 0;
                  armed[c]  = 1;
               end else if (!m_level[c]) begin
                  armed[c] = 0;
               end else if (armed[c] && tick_now) begin
                  tcount[c]++;
                  if (tcount[c] == LT) begin
                     e_long[c] = 1'b1;
                     armed[c]  = 0;
                  end
               end
               lvl_prev[c] = m_level[c];
               e_level[c]  = m_level[c];
            end
            d3 = d2; d2 = d1; d1 = cur_d;
            i2 = i1; i1 = cur_i;
         end
         #1;
         check_eq("model_level", int'(btn_level), int'(e_level));
         check_eq("model_pulse", int'(btn_pulse), int'(e_pulse));
         check_eq("model_long",  int'(btn_long),  int'(e_long));
         for (int c = 0; c < NB; c++) begin
            if (btn_level[c] && !mon_prev[c]) rise_at[c] = deb_rises;
            if (btn_pulse[c]) pulse_cnt[c]++;
            if (btn_long[c]) begin
               long_cnt[c]++;
               long_at[c] = deb_rises;
            end
         end
         mon_prev = btn_level;
         if (cap_en && !cap_done && btn_pulse != '0) begin
            cap_word = btn_pulse;
            cap_done = 1'b1;
         end
      end
   end

   task automatic tick_n(input int n);
      repeat (n) begin
         @(negedge clk);
         clk_debounce = 1'b1;
         deb_rises++;
         repeat (4) @(negedge clk);
         clk_debounce = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      int start_r, base_p, snap;
      rst_n        = 1'b0;
      clk_debounce = 1'b0;
      btn_in       = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", int'({btn_level, btn_pulse, btn_long}), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Clean press on channel 0
      start_r   = deb_rises;
      btn_in[0] = 1'b1;
      tick_n(10);
      check_range("t1_rise_ticks", rise_at[0] - start_r, DL, DL + 1);
      check_eq("t1_level", int'(btn_level[0]), 1);
      check_eq("t1_pulses", pulse_cnt[0], 1);
      btn_in[0] = 1'b0;
      tick_n(6);
      check_eq("t1_release_level", int'(btn_level[0]), 0);
      check_eq("t1_pulses_after", pulse_cnt[0], 1);
      check_eq("t1_longs", long_cnt[0], 0);

      // Bouncing channel 1: alternating samples never fill the window
      for (int k = 0; k < 20; k++) begin
         btn_in[1] = ~btn_in[1];
         tick_n(1);
      end
      btn_in[1] = 1'b0;
      tick_n(5);
      check_eq("t2_level", int'(btn_level[1]), 0);
      check_eq("t2_pulses", pulse_cnt[1], 0);
      check_eq("t2_longs", long_cnt[1], 0);

      // Long hold on channel 2
      btn_in[2] = 1'b1;
      tick_n(80);
      check_eq("t3_pulses", pulse_cnt[2], 1);
      check_eq("t3_longs", long_cnt[2], 1);
      check_eq("t3_long_delay", long_at[2] - rise_at[2], 64);
      btn_in[2] = 1'b0;
      tick_n(8);
      check_eq("t3_release_level", int'(btn_level[2]), 0);
      check_eq("t3_pulses_after", pulse_cnt[2], 1);
      check_eq("t3_longs_after", long_cnt[2], 1);

      // Simultaneous press on channels 0, 1, 3
      cap_en = 1'b1;
      btn_in = 4'b1011;
      tick_n(6);
      check_eq("t4_pulse_word", int'(cap_word), 4'b1011);
      check_eq("t4_level", int'(btn_level), 4'b1011);
      check_eq("t4_ch2_pulses", pulse_cnt[2], 1);
      btn_in = 4'b0000;
      tick_n(6);
      check_eq("t4_release_level", int'(btn_level), 0);

      // Reset in the middle of a press on channel 3
      btn_in[3] = 1'b1;
      tick_n(9);
      check_eq("t5_pressed_level", int'(btn_level[3]), 1);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_eq("t5_reset_outputs", int'({btn_level, btn_pulse, btn_long}), 0);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      start_r = deb_rises;
      base_p  = pulse_cnt[3];
      tick_n(6);
      check_eq("t5_pulses_after_reset", pulse_cnt[3] - base_p, 1);
      check_range("t5_rise_ticks", rise_at[3] - start_r, DL, DL + 1);
      check_eq("t5_longs", long_cnt[3], 0);

      // Frozen debounce clock: inputs change but nothing may move
      snap      = int'(btn_level);
      base_p    = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
      btn_in[0] = 1'b1;
      btn_in[3] = 1'b0;
      repeat (100) @(negedge clk);
      check_eq("t6_level_frozen", int'(btn_level), snap);
      check_eq("t6_no_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3], base_p);
      check_eq("t6_no_longs", long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 4: number of independent pushbutton channels.
REQ-002 Parameter DEB_LEN, default 4: consecutive equal debounce-tick samples required to change a debounced level.
REQ-003 Parameter LONG_TICKS, default 64: debounce ticks of continuous press before a long-press pulse.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1: crystal clock; all flops on rising edge.
REQ-006 rst_n  input  1: asynchronous, active-low reset.
REQ-007 clk_debounce  input  1: divided debounce clock from the frequency divider, treated as data only, never as a clock.
REQ-008 btn_in  input  NUM_BTN: raw, asynchronous, active-high pushbuttons.
REQ-009 btn_level  output  NUM_BTN: debounced button levels.
REQ-010 btn_pulse  output  NUM_BTN: one-clk-cycle press pulse per button.
REQ-011 btn_long  output  NUM_BTN: one-clk-cycle long-press pulse per button.

Function
REQ-012 btn_in and clk_debounce SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 tick SHALL assert for exactly one clk cycle on each rising edge of synchronized clk_debounce; it is shared by all channels.
REQ-014 On tick, each channel SHALL shift its synchronized input into a DEB_LEN-bit shift register; no shift occurs without tick.
REQ-015 btn_level SHALL become 1 in the cycle after a tick leaves the shift register all ones, become 0 after all zeros, and otherwise hold.
REQ-016 Per-channel FSM states: IDLE (level 0), PRESSED (level 1, counting), HELD (long press reported).
REQ-017 IDLE->PRESSED on level 0->1: btn_pulse high for exactly one clk cycle; long counter cleared.
REQ-018 In PRESSED, the long counter SHALL increment by 1 per tick; when it reaches LONG_TICKS-1 on a tick, go to HELD with btn_long high for one clk cycle.
REQ-019 In HELD, the counter SHALL saturate; no further btn_long until a release and new press.
REQ-020 PRESSED or HELD -> IDLE on level 1->0; counter cleared; no output pulse on release.
REQ-021 The counter SHALL be clog2(LONG_TICKS) bits wide and never wrap.
REQ-022 Channels SHALL be fully independent; simultaneous presses produce simultaneous pulses.
REQ-023 Latency from a clean input edge to btn_pulse: 2 clk sync, plus up to DEB_LEN+1 ticks, plus 1 clk.
REQ-024 A bounce shorter than DEB_LEN ticks SHALL produce no level change and no pulse.

Reset
REQ-025 With rst_n low: synchronizers, tick detector and shift registers 0; FSMs IDLE; counters 0; btn_level, btn_pulse, btn_long all 0.
REQ-026 Reset asserted mid-press SHALL abort the press; after release of reset, a still-held button SHALL produce one btn_pulse after a full debounce.
REQ-027 No output pulse SHALL be generated by reset assertion or deassertion alone.

Structure
REQ-028 Default NUM_BTN, DEB_LEN, LONG_TICKS and FSM state encodings SHALL be defined in the shared global defines file.
REQ-029 A single per-channel sub-module btn_debounce_cell (shift register, FSM, counter) SHALL be instantiated NUM_BTN times via generate; tick generation and synchronizers stay in the top.

Verification
REQ-030 btn_in[0] held 1 for 10 ticks, defaults -> btn_level[0]=1 within 5 ticks, one btn_pulse[0], no btn_long.
REQ-031 btn_in[1] toggling every tick for 20 ticks, then 0 -> btn_level[1] stays 0, no pulses.
REQ-032 btn_in[2] held 1 for 80 ticks -> one btn_pulse[2], one btn_long[2] 64 ticks after level rise, nothing more; release -> level 0, no pulse.
REQ-033 btn_in=4'b1011 applied together -> btn_pulse=4'b1011 in the same cycle, bit 2 stays 0.
REQ-034 rst_n low for 3 clk during PRESSED with btn_in[3]=1 held -> all outputs 0 during reset; one btn_pulse[3] after DEB_LEN ticks.
REQ-035 clk_debounce held constant for 100 clk -> no tick, no shift, outputs unchanged.
